// File: rtl/pipeline_pkg.sv
// Shared constants for the RV32I pipeline: datapath width, ALU opcodes and
// forwarding-select encodings.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU: add, sub, and, or, signed slt; unknown opcodes yield 0.
module alu
    import pipeline_pkg::*;
#(
    parameter int XLEN = pipeline_pkg::XLEN
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage with operand forwarding, branch resolution and the EX/MEM register.
module execute_cycle
    import pipeline_pkg::*;
#(
    parameter int XLEN = pipeline_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Reserved select 2'b11 falls back to the register file so no X escapes.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        src_b_fwd = RD2_E;
        case (ForwardB_E)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = ALU_ResultM;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu #(.XLEN(XLEN)) u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Store data is the forwarded rs2, never the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= src_b_fwd;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: reset, forwarding paths, branch and ALU ops.
module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [31:0] ResultW;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    int tests = 0;
    int fails = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .RD_E        (RD_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ResultW     (ResultW),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        RegWriteE   = 1'b0;
        ALUSrcE     = 1'b0;
        MemWriteE   = 1'b0;
        ResultSrcE  = 1'b0;
        BranchE     = 1'b0;
        ALUControlE = 3'b000;
        RD1_E       = '0;
        RD2_E       = '0;
        Imm_Ext_E   = '0;
        RD_E        = '0;
        PCE         = '0;
        PCPlus4E    = '0;
        ResultW     = '0;
        ForwardA_E  = 2'b00;
        ForwardB_E  = 2'b00;
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, " RegWriteM"},   {31'b0, RegWriteM},  32'd0);
        check({tag, " MemWriteM"},   {31'b0, MemWriteM},  32'd0);
        check({tag, " ResultSrcM"},  {31'b0, ResultSrcM}, 32'd0);
        check({tag, " RD_M"},        {27'b0, RD_M},       32'd0);
        check({tag, " PCPlus4M"},    PCPlus4M,            32'd0);
        check({tag, " WriteDataM"},  WriteDataM,          32'd0);
        check({tag, " ALU_ResultM"}, ALU_ResultM,         32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1;
        RD1_E = 32'd5; RD2_E = 32'd7; RD_E = 5'd9; PCPlus4E = 32'h44;
        step();
        check_regs_zero("por");
        // Branch resolution is combinational and must work even in reset.
        BranchE = 1'b1; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9;
        #1;
        check("pcsrc_in_reset", {31'b0, PCSrcE}, 32'd1);

        // No forwarding add
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        RD1_E = 32'd5; RD2_E = 32'd7; ALUControlE = 3'b000; RD_E = 5'd3;
        RegWriteE = 1'b1; PCPlus4E = 32'h1004; ResultSrcE = 1'b1;
        step();
        check("add ALU_ResultM", ALU_ResultM, 32'd12);
        check("add RD_M", {27'b0, RD_M}, 32'd3);
        check("add RegWriteM", {31'b0, RegWriteM}, 32'd1);
        check("add WriteDataM", WriteDataM, 32'd7);
        check("add PCPlus4M", PCPlus4M, 32'h1004);
        check("add ResultSrcM", {31'b0, ResultSrcM}, 32'd1);
        check("add MemWriteM", {31'b0, MemWriteM}, 32'd0);

        // Asynchronous reset mid-cycle, held across an edge
        #2;
        rst = 1'b0;
        #1;
        check_regs_zero("async_rst");
        step();
        check_regs_zero("held_rst");
        @(negedge clk);
        rst = 1'b1;

        // MEM forward on A, back-to-back
        idle_inputs();
        RD1_E = 32'd4; RD2_E = 32'd6; ALUControlE = 3'b000;
        step();
        check("mem_fwd setup", ALU_ResultM, 32'd10);
        ForwardA_E = 2'b10; RD1_E = 32'd0; RD2_E = 32'd4; ALUControlE = 3'b001;
        step();
        check("mem_fwd sub", ALU_ResultM, 32'd6);

        // WB forward on B with immediate operand
        idle_inputs();
        ForwardB_E = 2'b01; ResultW = 32'h55; ALUSrcE = 1'b1; Imm_Ext_E = 32'd8;
        RD1_E = 32'd2; RD2_E = 32'h77; MemWriteE = 1'b1; ALUControlE = 3'b000;
        step();
        check("wb_fwd ALU_ResultM", ALU_ResultM, 32'd10);
        check("wb_fwd WriteDataM", WriteDataM, 32'h55);
        check("wb_fwd MemWriteM", {31'b0, MemWriteM}, 32'd1);

        // Branch taken / not taken with wrapping target
        idle_inputs();
        BranchE = 1'b1; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9;
        PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0;
        #1;
        check("beq taken", {31'b0, PCSrcE}, 32'd1);
        check("beq target", PCTargetE, 32'h0000_00F0);
        RD2_E = 32'd8;
        #1;
        check("beq not taken", {31'b0, PCSrcE}, 32'd0);
        PCE = 32'hFFFF_FFFC; Imm_Ext_E = 32'd8;
        #1;
        check("target wrap", PCTargetE, 32'd4);

        // SLT signed, both orders
        idle_inputs();
        ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
        step();
        check("slt -1<1", ALU_ResultM, 32'd1);
        RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF;
        step();
        check("slt 1<-1", ALU_ResultM, 32'd0);

        // Logic ops and undefined opcodes
        ALUControlE = 3'b010; RD1_E = 32'h0000_F0F0; RD2_E = 32'h0000_0FF0;
        step();
        check("and", ALU_ResultM, 32'h0000_00F0);
        ALUControlE = 3'b011;
        step();
        check("or", ALU_ResultM, 32'h0000_FFF0);
        ALUControlE = 3'b111;
        step();
        check("op111", ALU_ResultM, 32'd0);
        ALUControlE = 3'b100;
        step();
        check("op100", ALU_ResultM, 32'd0);
        ALUControlE = 3'b110;
        step();
        check("op110", ALU_ResultM, 32'd0);

        // Reserved forward select falls back to the register file
        idle_inputs();
        ALUControlE = 3'b000; ResultW = 32'h99; RD1_E = 32'd3; RD2_E = 32'd4;
        step();
        check("fwd11 setup", ALU_ResultM, 32'd7);
        ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'd20; RD2_E = 32'd30;
        step();
        check("fwd11 ALU_ResultM", ALU_ResultM, 32'd50);
        check("fwd11 WriteDataM", WriteDataM, 32'd30);

        // MEM forward on B feeds store data
        ForwardA_E = 2'b00; ForwardB_E = 2'b10; RD1_E = 32'd1; RD2_E = 32'd0;
        step();
        check("mem_fwd_b ALU_ResultM", ALU_ResultM, 32'd51);
        check("mem_fwd_b WriteDataM", WriteDataM, 32'd50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
